// File: rtl/pcie_descrambler.sv
// -----------------------------------------------------------------------------
// pcie_descrambler
//   Receive-side descrambler for the 8b/10b (Gen1/Gen2) PCIe physical layer.
//   Sits after the 8b/10b decoder and removes the G(x) = x^16+x^5+x^4+x^3+1
//   keystream one symbol per valid cycle. COM symbols reseed the LFSR and
//   establish lock; SKP symbols freeze it so both ends stay aligned.
//
//   Optional feature (macro PCIE_DESCRAMBLER_LOCK_TIMEOUT_EN):
//     drop lock after COM_TIMEOUT valid symbols seen without a COM.
//
// Ports
//   clk_i      symbol clock, rising edge
//   rst_ni     asynchronous active-low reset
//   data_i     decoded symbol, bit 0 first on the wire
//   k_i        data_i is a control (K) symbol
//   valid_i    data_i/k_i carry a symbol this cycle
//   realign_i  single-cycle request from link training to drop lock
//   data_o     descrambled symbol (one cycle latency)
//   k_o        registered k_i
//   valid_o    registered valid_i
//   locked_o   descrambler is aligned to a received COM
// -----------------------------------------------------------------------------
module pcie_descrambler #(
  parameter int unsigned COM_TIMEOUT = 4096,
  parameter logic [15:0] LFSR_SEED   = 16'hFFFF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [7:0] data_i,
  input  logic       k_i,
  input  logic       valid_i,
  input  logic       realign_i,
  output logic [7:0] data_o,
  output logic       k_o,
  output logic       valid_o,
  output logic       locked_o
);

  localparam logic [0:0] ST_UNLOCKED = 1'b0;
  localparam logic [0:0] ST_LOCKED   = 1'b1;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_SKP = 8'h1C;

  // A zero limit would make the timeout fire on the very first symbol.
  if (COM_TIMEOUT < 1) begin : g_bad_timeout
    $error("COM_TIMEOUT must be at least 1");
  end

  // One Galois step of the scrambler polynomial.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:6], l[5], l[4] ^ l[15], l[3] ^ l[15], l[2] ^ l[15],
            l[1], l[0], l[15]};
  endfunction

  logic [0:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [7:0]  data_q, data_d;
  logic        k_q, k_d;
  logic        valid_q, valid_d;

  logic [15:0] lfsr_adv;   // LFSR after eight steps
  logic [7:0]  keystream;  // bit i = LFSR msb before step i

  // NOTE: inside always_comb, blocking assignments are intended: lfsr_adv is
  // rebuilt step by step in the loop, each step reading the previous result.
  always_comb begin
    lfsr_adv  = lfsr_q;
    keystream = '0;
    for (int i = 0; i < 8; i++) begin
      keystream[i] = lfsr_adv[15];
      lfsr_adv     = lfsr_step(lfsr_adv);
    end
  end

  logic is_com;
  logic eff_locked;   // state used for this cycle's symbol
  logic timeout_hit;

  assign is_com     = valid_i && k_i && (data_i == SYM_COM);
  // realign_i acts on the symbol of its own cycle, so it masks the lock here.
  assign eff_locked = (state_q == ST_LOCKED) && !realign_i;

`ifdef PCIE_DESCRAMBLER_LOCK_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(COM_TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = valid_i && eff_locked && !is_com &&
                       (cnt_inc == CNT_W'(COM_TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    if (is_com || !eff_locked) begin
      cnt_d = '0;
    end else if (valid_i) begin
      cnt_d = timeout_hit ? '0 : cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // NOTE: every output of this block gets a default first so no path leaves a
  // signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    data_d  = data_q;
    k_d     = k_q;
    valid_d = valid_i;

    // Invalid cycles hold the data/k outputs; only valid_o follows the input.
    if (valid_i) begin
      data_d = data_i;
      k_d    = k_i;
    end

    if (is_com) begin
      // COM always passes raw and wins over a simultaneous realign.
      state_d = ST_LOCKED;
      lfsr_d  = LFSR_SEED;
    end else if (!eff_locked) begin
      // Unlocked: pass through and keep the LFSR parked at the seed.
      state_d = ST_UNLOCKED;
      lfsr_d  = LFSR_SEED;
    end else if (valid_i) begin
      if (!k_i) data_d = data_i ^ keystream;
      if (!(k_i && data_i == SYM_SKP)) lfsr_d = lfsr_adv;
      // The limit-reaching symbol is still descrambled; lock drops after it.
      if (timeout_hit) begin
        state_d = ST_UNLOCKED;
        lfsr_d  = LFSR_SEED;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_UNLOCKED;
      lfsr_q  <= LFSR_SEED;
      data_q  <= '0;
      k_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      data_q  <= data_d;
      k_q     <= k_d;
      valid_q <= valid_d;
    end
  end

  assign data_o   = data_q;
  assign k_o      = k_q;
  assign valid_o  = valid_q;
  // State updates on the same edge as the output register, so it lines up
  // with the symbol that caused the change.
  assign locked_o = (state_q == ST_LOCKED);

endmodule

// File: doc/pcie_descrambler.md
# pcie_descrambler

- Receive-side descrambler for the 8b/10b (Gen1/Gen2) PCIe physical layer.
- Placement: after the 8b/10b decoder, before ordered-set and packet parsing.
- Function: removes the G(x) = x^16 + x^5 + x^4 + x^3 + 1 keystream that the transmit scrambler applied, one symbol per valid cycle.
- Also tracks COM/SKP control symbols to keep its LFSR aligned with the far end, and reports lock status.

## Interface
Parameters:
- COM_TIMEOUT, default 4096: valid symbols allowed without a COM while locked before lock is dropped (only used with the timeout feature).
- LFSR_SEED, default 16'hFFFF: value loaded into the LFSR on reset and on every COM.

Ports:
- clk_i  in  1  symbol clock; all logic on rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- data_i  in  8  decoded symbol, bit 0 first on the wire.
- k_i  in  1  data_i is a K (control) symbol.
- valid_i  in  1  data_i/k_i carry a symbol this cycle.
- realign_i  in  1  single-cycle request to drop lock (from the link training state machine).
- data_o  out  8  descrambled symbol.
- k_o  out  1  registered copy of k_i.
- valid_o  out  1  registered copy of valid_i.
- locked_o  out  1  descrambler is aligned to a received COM.

## Operation
- LFSR: 16-bit Galois form using the same taps as the transmit scrambler. Per bit step:
  - next = {l[14:6], l[5], l[4]^l[15], l[3]^l[15], l[2]^l[15], l[1], l[0], l[15]}.
  - The keystream bit is l[15], taken before the step.
- Per valid D symbol while LOCKED: data bit i (i = 0..7) is XORed with the keystream bit from step i, and the LFSR advances 8 steps.
- Keystream check: after a seed of FFFF, the first 8 keystream bytes are FF 17 C0 14 B2 E7 02 82.
- K symbols are never descrambled.
  - COM (K, 8'hBC): LFSR loads LFSR_SEED; the next symbol uses the seed.
  - SKP (K, 8'h1C): LFSR holds.
  - Any other K symbol: LFSR advances 8 steps.
- Invalid cycles (valid_i = 0): nothing advances. Outputs other than valid_o hold their values.
- State machine, two states:
  - UNLOCKED (reset state): symbols pass through unmodified and the LFSR is held at LFSR_SEED.
  - UNLOCKED -> LOCKED on any valid COM.
  - LOCKED -> UNLOCKED on realign_i = 1, or on timeout (see Configuration).
- locked_o = 1 exactly when the state is LOCKED.
- Simultaneous realign_i and a valid COM: COM wins. The result is LOCKED with the LFSR seeded.
- realign_i while UNLOCKED: no effect.

## Timing
- Latency: one cycle. Input at edge N appears on data_o/k_o/valid_o after edge N+1.
- The symbol that causes a state change is itself processed under the old state:
  - The COM that locks is output unmodified, and locked_o rises together with it on the output.
  - A realign_i pulse takes effect for the symbol in the same cycle.
- Reset (asynchronous assert, synchronous release):
  - data_o = 8'h00, k_o = 0, valid_o = 0, locked_o = 0.
  - LFSR = LFSR_SEED, timeout counter = 0, state UNLOCKED.
- Reset mid-stream: outputs clear immediately. The first symbol after release is treated as UNLOCKED.
- Throughput: one symbol per cycle with no back-pressure. valid_i may toggle every cycle.

## Configuration
- Macro: PCIE_DESCRAMBLER_LOCK_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(COM_TIMEOUT+1) counts valid symbols while LOCKED.
  - Any COM clears the counter.
  - When the counter reaches COM_TIMEOUT, the state returns to UNLOCKED and the counter clears.
  - locked_o falls with the output of the symbol that reached the limit.
- Undefined:
  - No counter is built and COM_TIMEOUT is ignored.
  - LOCKED is left only on realign_i or reset.

## Test plan
- Reset, then feed D symbols 8'h55 with no COM -> data_o = 8'h55 each cycle, locked_o = 0.
- Feed COM (K, BC), then D symbols FF 17 C0 14 B2 E7 02 82 -> data_o = BC with k_o = 1, then eight 8'h00; locked_o = 1 from the COM output onward.
- Feed COM, FF, SKP, SKP, 17 -> data_o = BC, 00, 1C, 1C, 00. SKP does not advance the LFSR and passes with k_o = 1.
- Feed COM, FF, then deassert valid_i for 3 cycles, then 17 -> valid_o = 0 for 3 cycles, then 17 descrambles to 00.
- While LOCKED:
  - Pulse realign_i with a D symbol -> locked_o = 0 on that output and the data passes raw.
  - realign_i in the same cycle as a COM -> locked_o stays 1.
- With PCIE_DESCRAMBLER_LOCK_TIMEOUT_EN defined and COM_TIMEOUT = 16: COM, then 16 D symbols -> locked_o drops on the 16th D output. With the macro undefined, locked_o stays 1.
